// File: rtl/m_data_mem_pkg.sv
// Shared constants for the M-stage data memory.
// DMOp encodings, window base and default depth.
package m_data_mem_pkg;

    localparam logic [2:0] DMOP_W  = 3'd0;
    localparam logic [2:0] DMOP_H  = 3'd1;
    localparam logic [2:0] DMOP_HU = 3'd2;
    localparam logic [2:0] DMOP_B  = 3'd3;
    localparam logic [2:0] DMOP_BU = 3'd4;

    localparam logic [31:0] DM_BASE      = 32'h0000_0000;
    localparam int          DM_WORDS_DEF = 3072;

    // True when the lane offset does not suit the access size.
    function automatic logic dm_misaligned(
        input logic [2:0] op,
        input logic [1:0] lane
    );
        logic m;
        m = 1'b0;
        if (op == DMOP_W)
            m = (lane != 2'b00);
        else if (op == DMOP_H || op == DMOP_HU)
            m = lane[0];
        return m;
    endfunction

endpackage

// File: rtl/m_data_mem_ext.sv
// Load lane selection and sign/zero extension.
// Purely combinational; fed the raw array word.
module dm_ext
    import m_data_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] rd_o
);

    logic [15:0] half;
    logic [7:0]  byt;

    assign half = lane_i[1] ? word_i[31:16] : word_i[15:0];

    // Pick the addressed byte lane (little-endian).
    always_comb begin
        byt = word_i[7:0];
        case (lane_i)
            2'd0: byt = word_i[7:0];
            2'd1: byt = word_i[15:8];
            2'd2: byt = word_i[23:16];
            2'd3: byt = word_i[31:24];
            default: byt = word_i[7:0];
        endcase
    end

    // Extend the selected lane according to the access type.
    always_comb begin
        rd_o = '0;
        case (op_i)
            DMOP_W:  rd_o = word_i;
            DMOP_H:  rd_o = {{16{half[15]}}, half};
            DMOP_HU: rd_o = {16'h0000, half};
            DMOP_B:  rd_o = {{24{byt[7]}}, byt};
            DMOP_BU: rd_o = {24'h000000, byt};
            default: rd_o = '0;
        endcase
    end

endmodule

// File: rtl/m_data_mem.sv
// M-stage data memory: word array, store merge, sticky fault capture.
// Define DM_TRACE_EN to print every committed store.
module m_data_mem
    import m_data_mem_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WD,
    input  logic [2:0]  M_DMOp,
    input  logic        M_WE,
    output logic [31:0] M_RD,
    output logic        M_DMErr,
    output logic [31:0] M_ErrPC
);

    localparam logic [32:0] LIMIT = 33'(DM_WORDS) * 33'd4;

    logic [31:0] mem_q [DM_WORDS];
    logic        err_q, err_d;
    logic [31:0] errpc_q, errpc_d;

    logic [31:0] off;
    logic [11:0] widx;
    logic [1:0]  lane;
    logic        in_range;
    logic        misal;
    logic        ld_op;
    logic        st_op;
    logic        rd_ok;
    logic        st_ok;
    logic        fault;
    logic [31:0] word_rd;
    logic [31:0] ext_rd;
    logic [31:0] wdata_d;

    assign off      = M_Addr - DM_BASE;
    assign widx     = off[13:2];
    assign lane     = off[1:0];
    assign in_range = {1'b0, off} < LIMIT;
    assign misal    = dm_misaligned(M_DMOp, lane);
    assign ld_op    = (M_DMOp <= DMOP_BU);
    assign st_op    = (M_DMOp == DMOP_W) ||
                      (M_DMOp == DMOP_H) ||
                      (M_DMOp == DMOP_B);
    assign rd_ok    = ld_op && !misal && in_range;
    assign st_ok    = M_WE && st_op && !misal && in_range;

    // Any illegal store, or an illegal load of a valid load type.
    assign fault    = M_WE ? !st_ok : (ld_op && !rd_ok);

    // Out-of-window indices never touch the array.
    assign word_rd  = in_range ? mem_q[widx] : '0;

    dm_ext u_ext (
        .word_i (word_rd),
        .op_i   (M_DMOp),
        .lane_i (lane),
        .rd_o   (ext_rd)
    );

    assign M_RD = rd_ok ? ext_rd : '0;

    // Merge store data into the addressed lanes of the old word.
    always_comb begin
        wdata_d = word_rd;
        case (M_DMOp)
            DMOP_W: wdata_d = M_WD;
            DMOP_H: begin
                if (lane[1])
                    wdata_d[31:16] = M_WD[15:0];
                else
                    wdata_d[15:0] = M_WD[15:0];
            end
            DMOP_B: begin
                case (lane)
                    2'd0: wdata_d[7:0]   = M_WD[7:0];
                    2'd1: wdata_d[15:8]  = M_WD[7:0];
                    2'd2: wdata_d[23:16] = M_WD[7:0];
                    2'd3: wdata_d[31:24] = M_WD[7:0];
                    default: wdata_d = word_rd;
                endcase
            end
            default: wdata_d = word_rd;
        endcase
    end

    // Array: cleared by reset, legal stores commit on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++)
                mem_q[i] <= '0;
        end else if (st_ok) begin
            mem_q[widx] <= wdata_d;
        end
    end

    // Only the first fault after reset records its PC.
    always_comb begin
        err_d   = err_q;
        errpc_d = errpc_q;
        if (fault && !err_q) begin
            err_d   = 1'b1;
            errpc_d = M_PC;
        end
    end

    // Sticky fault flag and PC, held until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q   <= 1'b0;
            errpc_q <= '0;
        end else begin
            err_q   <= err_d;
            errpc_q <= errpc_d;
        end
    end

    assign M_DMErr = err_q;
    assign M_ErrPC = errpc_q;

`ifdef DM_TRACE_EN
    // Store trace: one line per committed write.
    always @(posedge clk) begin
        if (!reset && st_ok)
            $display("%0t@%08h: *%08h <= %08h", $time, M_PC,
                     {M_Addr[31:2], 2'b00}, wdata_d);
    end
`else
`endif

endmodule

// File: tb/tb_m_data_mem.sv
// Randomized bench for m_data_mem against a byte-level memory model.
// Directed literal checks pin the model first.
module tb_m_data_mem;

    localparam int WORDS = 3072;
    localparam int NB    = WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC, M_Addr, M_WD;
    logic [2:0]  M_DMOp;
    logic        M_WE;
    logic [31:0] M_RD, M_ErrPC;
    logic        M_DMErr;

    m_data_mem #(.DM_WORDS(WORDS)) dut (
        .clk     (clk),
        .reset   (reset),
        .M_PC    (M_PC),
        .M_Addr  (M_Addr),
        .M_WD    (M_WD),
        .M_DMOp  (M_DMOp),
        .M_WE    (M_WE),
        .M_RD    (M_RD),
        .M_DMErr (M_DMErr),
        .M_ErrPC (M_ErrPC)
    );

    always #5 clk = ~clk;

    logic [7:0]  mb [NB];
    bit          merr;
    logic [31:0] mpc;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic int unsigned sz(input logic [2:0] op);
        if (op == 3'd0) return 4;
        if (op == 3'd1 || op == 3'd2) return 2;
        return 1;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return a < 32'(NB);
    endfunction

    function automatic bit rd_ok(input logic [2:0] op, input logic [31:0] a);
        return op <= 3'd4 && in_win(a) && (a % sz(op)) == 0;
    endfunction

    function automatic bit st_ok(input logic [2:0] op, input logic [31:0] a);
        return (op == 3'd0 || op == 3'd1 || op == 3'd3) &&
               in_win(a) && (a % sz(op)) == 0;
    endfunction

    function automatic bit is_fault(input logic [2:0] op,
                                    input logic [31:0] a, input logic we);
        if (we) return !st_ok(op, a);
        return op <= 3'd4 && !rd_ok(op, a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] op,
                                           input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (!rd_ok(op, a)) return '0;
        for (int i = 0; i < int'(sz(op)); i++)
            v = v | (32'(mb[int'(a) + i]) << (8 * i));
        if (op == 3'd1) v = {{16{v[15]}}, v[15:0]};
        if (op == 3'd3) v = {{24{v[7]}}, v[7:0]};
        return v;
    endfunction

    task automatic clear_model();
        foreach (mb[i]) mb[i] = 8'h00;
        merr = 1'b0;
        mpc  = '0;
    endtask

    task automatic cmp(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] op,
                         input logic we);
        M_PC = pc; M_Addr = a; M_WD = wd; M_DMOp = op; M_WE = we;
        #3;
    endtask

    // Per-cycle comparison of all outputs against the model.
    task automatic check_model();
        cmp("rd", M_RD, exp_rd(M_DMOp, M_Addr));
        cmp("err", {31'b0, M_DMErr}, {31'b0, merr});
        cmp("errpc", M_ErrPC, mpc);
    endtask

    // Advance one edge and apply its effect to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (is_fault(M_DMOp, M_Addr, M_WE) && !merr) begin
                merr = 1'b1;
                mpc  = M_PC;
            end
            if (M_WE && st_ok(M_DMOp, M_Addr)) begin
                for (int i = 0; i < int'(sz(M_DMOp)); i++)
                    mb[int'(M_Addr) + i] = M_WD[8*i +: 8];
            end
        end
        #1;
    endtask

    task automatic step(input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] op,
                        input logic we);
        drive(pc, a, wd, op, we);
        check_model();
        tick();
    endtask

    // Async reset mid-cycle, with a store held across the reset edge.
    task automatic reset_mid();
        drive(32'h0, 32'h4, 32'h0, 3'd0, 1'b0);
        reset = 1'b1;
        clear_model();
        #1;
        cmp("rst_rd", M_RD, 32'h0);
        cmp("rst_err", {31'b0, M_DMErr}, 32'h0);
        cmp("rst_errpc", M_ErrPC, 32'h0);
        check_model();
        M_Addr = 32'h0; M_WD = 32'hFFFF_FFFF; M_WE = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        M_WE = 1'b0;
        #1;
        cmp("rst_store_drop", M_RD, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, pc, wd;
        logic [2:0]  op;
        logic        we;
        int          sel;

        reset = 1'b1;
        M_PC = '0; M_Addr = '0; M_WD = '0; M_DMOp = 3'd0; M_WE = 1'b0;
        clear_model();
        #16;
        reset = 1'b0;
        #1;
        cmp("reset_err", {31'b0, M_DMErr}, 32'h0);
        cmp("reset_errpc", M_ErrPC, 32'h0);
        cmp("reset_rd", M_RD, 32'h0);

        step(32'h100, 32'h0, 32'h1234_5678, 3'd0, 1'b1);
        drive(32'h104, 32'h0, 32'h0, 3'd0, 1'b0);
        cmp("lw0", M_RD, 32'h1234_5678);
        check_model(); tick();

        step(32'h108, 32'h4, 32'h1234_5678, 3'd0, 1'b1);
        step(32'h10C, 32'h5, 32'h0000_00AB, 3'd3, 1'b1);
        drive(32'h110, 32'h4, 32'h0, 3'd0, 1'b0);
        cmp("lw4", M_RD, 32'h1234_AB78);
        check_model(); tick();
        drive(32'h114, 32'h5, 32'h0, 3'd3, 1'b0);
        cmp("lb5", M_RD, 32'hFFFF_FFAB);
        check_model(); tick();
        drive(32'h118, 32'h5, 32'h0, 3'd4, 1'b0);
        cmp("lbu5", M_RD, 32'h0000_00AB);
        check_model(); tick();

        step(32'h11C, 32'h8, 32'h1111_2222, 3'd0, 1'b1);
        step(32'h120, 32'hA, 32'h0000_8001, 3'd1, 1'b1);
        drive(32'h124, 32'hA, 32'h0, 3'd1, 1'b0);
        cmp("lhA", M_RD, 32'hFFFF_8001);
        check_model(); tick();
        drive(32'h128, 32'hA, 32'h0, 3'd2, 1'b0);
        cmp("lhuA", M_RD, 32'h0000_8001);
        check_model(); tick();
        drive(32'h12C, 32'h8, 32'h0, 3'd0, 1'b0);
        cmp("lw8", M_RD, 32'h8001_2222);
        check_model(); tick();

        step(32'h3010, 32'h2, 32'h5555_5555, 3'd0, 1'b1);
        drive(32'h130, 32'h0, 32'h0, 3'd0, 1'b0);
        cmp("mis_word", M_RD, 32'h1234_5678);
        cmp("mis_err", {31'b0, M_DMErr}, 32'h1);
        cmp("mis_errpc", M_ErrPC, 32'h3010);
        check_model(); tick();
        step(32'h4000, 32'h3000, 32'h1, 3'd0, 1'b1);
        drive(32'h134, 32'h2FFC, 32'h0, 3'd0, 1'b0);
        cmp("oob_errpc", M_ErrPC, 32'h3010);
        check_model(); tick();

        step(32'h138, 32'h10, 32'hCAFE_F00D, 3'd0, 1'b1);
        drive(32'h13C, 32'h10, 32'hDEAD_BEEF, 3'd0, 1'b1);
        cmp("rdw_old", M_RD, 32'hCAFE_F00D);
        check_model(); tick();
        drive(32'h140, 32'h10, 32'h0, 3'd0, 1'b0);
        cmp("rdw_new", M_RD, 32'hDEAD_BEEF);
        check_model(); tick();

        reset_mid();

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 600; c++) begin
                op  = 3'($urandom_range(0, 5));
                we  = ($urandom_range(0, 2) == 0);
                wd  = $urandom;
                pc  = $urandom;
                sel = $urandom_range(0, 9);
                if (sel < 5)      a = 32'($urandom_range(0, 63));
                else if (sel < 8) a = 32'($urandom_range(0, NB - 1));
                else if (sel == 8) a = 32'(NB - 8 + $urandom_range(0, 15));
                else              a = $urandom;
                if (sel < 8 && $urandom_range(0, 3) != 0)
                    a = a & ~(32'(sz(op)) - 32'd1);
                step(pc, a, wd, op, we);
            end
            reset_mid();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
